// File: rtl/receiver_framer.sv
// receiver_framer
//   Frame aligner and descrambler for a 9-bit word channel. A frame is 16
//   words. Word 0 is the sync word 9'h0A5, and words 1..15 are payload
//   scrambled with an 8-bit Fibonacci LFSR that is reseeded on every word 0.
//   The framer needs two sync words, one frame apart, to reach LOCK. It
//   drops back to HUNT after three consecutive frames without a sync word.
//   Payload is output only while in LOCK.
// Ports
//   sys_clk     rising-edge clock
//   reset       async active-low reset
//   init_tab    sync reinit: force HUNT, clear counters and strobes
//   IsReceive   word enable; channel_in is sampled only when high
//   channel_in  [7:0] data, [8] even-parity bit
//   data_out    descrambled payload byte (holds between strobes)
//   data_valid  one-cycle strobe for data_out
//   parity_err  one-cycle strobe with data_valid when word parity is bad
//   locked      framer is in LOCK
//   err_count   saturating count of payload parity errors
module receiver_framer (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        init_tab,
  input  logic        IsReceive,
  input  logic [8:0]  channel_in,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        parity_err,
  output logic        locked,
  output logic [15:0] err_count
);

  localparam logic [8:0] SYNC = 9'h0A5;
  localparam logic [7:0] SEED = 8'hFF;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] miss;
  logic [7:0] lfsr;

  logic       is_sync;
  logic       par_bad;
  logic [7:0] lfsr_nxt;

  // Exact 9-bit match, so a sync word with bad parity never matches and
  // counts as a miss.
  assign is_sync  = (channel_in == SYNC);
  assign par_bad  = ^channel_in;
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      cnt        <= 4'd0;
      miss       <= 2'd0;
      lfsr       <= SEED;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      locked     <= 1'b0;
      err_count  <= 16'h0000;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      if (init_tab) begin
        // Takes priority over a word accepted on the same edge; that word
        // is discarded.
        state     <= HUNT;
        cnt       <= 4'd0;
        miss      <= 2'd0;
        lfsr      <= SEED;
        locked    <= 1'b0;
        err_count <= 16'h0000;
      end else if (IsReceive) begin
        cnt <= cnt + 4'd1;
        unique case (state)
          HUNT: begin
            // A sync word found while hunting is taken as position 0.
            if (is_sync) begin
              state <= VERIFY;
              cnt   <= 4'd1;
              lfsr  <= SEED;
            end
          end
          VERIFY: begin
            if (cnt == 4'd0) begin
              lfsr <= SEED;
              if (is_sync) begin
                state  <= LOCK;
                locked <= 1'b1;
              end else begin
                state <= HUNT;
              end
            end else begin
              lfsr <= lfsr_nxt;
            end
          end
          LOCK: begin
            if (cnt == 4'd0) begin
              lfsr <= SEED;
              if (is_sync) begin
                miss <= 2'd0;
              end else if (miss == 2'd2) begin
                state  <= HUNT;
                locked <= 1'b0;
                miss   <= 2'd0;
              end else begin
                miss <= miss + 2'd1;
              end
            end else begin
              data_out   <= channel_in[7:0] ^ lfsr;
              data_valid <= 1'b1;
              parity_err <= par_bad;
              if (par_bad && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
              lfsr <= lfsr_nxt;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receiver_framer.sv
// tb_receiver_framer
//   Randomized and directed stimulus for receiver_framer. The bench keeps a
//   frame-level reference model: mode (hunting / one sync seen / locked),
//   position in the frame, and the count of missed syncs. The scrambler pad
//   for a payload position is computed directly from the seed.
module tb_receiver_framer;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_tab = 1'b0;
  logic        IsReceive = 1'b0;
  logic [8:0]  channel_in = 9'h000;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        parity_err;
  logic        locked;
  logic [15:0] err_count;

  receiver_framer dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .init_tab  (init_tab),
    .IsReceive (IsReceive),
    .channel_in(channel_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Reference model. mode values: 0 hunting, 1 one sync seen, 2 locked.
  int         m_mode, m_pos, m_miss, m_err;
  bit         m_dv, m_pe;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Pad byte for payload position p: the seed advanced p-1 times.
  function automatic logic [7:0] pad(input int p);
    logic [7:0] s;
    s = 8'hFF;
    for (int k = 1; k < p; k++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  function automatic logic [8:0] mkword(input logic [7:0] b, input bit good);
    logic p;
    p = good ? (^b) : ~(^b);
    return {p, b};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_miss = 0; m_err = 0;
    m_dv = 0; m_pe = 0; m_dout = 8'h00;
  endtask

  task automatic model_step(input bit ir, input logic [8:0] ch, input bit it);
    bit sy;
    m_dv = 0;
    m_pe = 0;
    sy = (ch == 9'h0A5);
    if (it) begin
      m_mode = 0; m_pos = 0; m_miss = 0; m_err = 0;
    end else if (ir) begin
      if (m_mode == 0) begin
        if (sy) begin
          m_mode = 1;
          m_pos  = 0;
        end
      end else if (m_mode == 1) begin
        if (m_pos == 0) m_mode = sy ? 2 : 0;
      end else begin
        if (m_pos == 0) begin
          if (sy) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == 3) begin
              m_mode = 0;
              m_miss = 0;
            end
          end
        end else begin
          m_dv   = 1;
          m_dout = ch[7:0] ^ pad(m_pos);
          m_pe   = ^ch;
          if (m_pe && m_err < 65535) m_err++;
        end
      end
      m_pos = (m_pos + 1) % 16;
    end
  endtask

  // One clock: drive at the falling edge, check at the next falling edge.
  task automatic cyc(input bit ir, input logic [8:0] ch, input bit it);
    IsReceive  = ir;
    channel_in = ch;
    init_tab   = it;
    @(posedge sys_clk);
    model_step(ir, ch, it);
    @(negedge sys_clk);
    chk("data_valid", {31'd0, data_valid}, {31'd0, m_dv});
    chk("parity_err", {31'd0, parity_err}, {31'd0, m_pe});
    if (m_dv) chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
    chk("locked", {31'd0, locked}, {31'd0, m_mode == 2});
    chk("err_count", {16'd0, err_count}, m_err);
  endtask

  // bmode: 0 = about 1 in 8 bad parity, 1 = all good, 2 = all bad.
  task automatic frame(input logic [8:0] w0, input int bmode, input bit gaps);
    cyc(1, w0, 0);
    for (int i = 1; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) cyc(0, 9'($urandom), 0);
      cyc(1, mkword(8'($urandom), bmode == 1 ? 1'b1 :
                                 bmode == 2 ? 1'b0 : ($urandom_range(0, 7) != 0)), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, {24'd0, data_out}, 32'h0);
    chk({tag, "_dv"}, {31'd0, data_valid}, 32'h0);
    chk({tag, "_pe"}, {31'd0, parity_err}, 32'h0);
    chk({tag, "_lock"}, {31'd0, locked}, 32'h0);
    chk({tag, "_err"}, {16'd0, err_count}, 32'h0);
  endtask

  int e0;

  initial begin
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge sys_clk);

    // Garbage words while hunting produce nothing.
    repeat (5) cyc(1, 9'($urandom), 0);

    // Two syncs reach lock; first payload 0FF descrambles to 00.
    frame(9'h0A5, 1, 0);
    cyc(1, 9'h0A5, 0);
    chk("lock_after_2nd_sync", {31'd0, locked}, 32'h1);
    cyc(1, 9'h0FF, 0);
    chk("first_payload", {23'd0, data_valid, data_out}, 32'h100);
    for (int i = 2; i < 16; i++) cyc(1, mkword(8'($urandom), 1), 0);

    // Random frames with idle gaps and occasional parity errors.
    repeat (6) frame(9'h0A5, 0, 1);

    // Bad-parity payload word.
    cyc(1, 9'h0A5, 0);
    e0 = m_err;
    cyc(1, 9'h1FF, 0);
    chk("badpar_pe", {30'd0, data_valid, parity_err}, 32'h3);
    chk("badpar_inc", {16'd0, err_count}, e0 + 1);
    for (int i = 2; i < 16; i++) cyc(1, mkword(8'($urandom), 1), 0);

    // Five idle cycles mid-frame: no strobes, descrambling resumes.
    cyc(1, 9'h0A5, 0);
    for (int i = 1; i < 6; i++) cyc(1, mkword(8'($urandom), 1), 0);
    repeat (5) begin
      cyc(0, 9'($urandom), 0);
      chk("idle_no_dv", {31'd0, data_valid}, 32'h0);
    end
    for (int i = 6; i < 16; i++) cyc(1, mkword(8'($urandom), 1), 0);

    // Two missed syncs keep lock; the third drops it.
    frame(9'h000, 1, 0);
    frame(9'h000, 1, 0);
    chk("lock_after_2_miss", {31'd0, locked}, 32'h1);
    frame(9'h000, 1, 0);
    chk("unlock_after_3_miss", {31'd0, locked}, 32'h0);
    frame(9'h0A5, 1, 0);
    chk("one_sync_not_locked", {31'd0, locked}, 32'h0);
    frame(9'h0A5, 0, 1);
    chk("relock", {31'd0, locked}, 32'h1);
    frame(9'h0A5, 2, 0);

    // A bad-parity sync word counts as a miss, not a parity error.
    e0 = m_err;
    frame(9'h1A5, 1, 0);
    chk("badsync_no_err", {16'd0, err_count}, e0);

    // init_tab coincident with a payload word.
    frame(9'h0A5, 1, 0);
    cyc(1, 9'h0A5, 0);
    cyc(1, mkword(8'h3C, 1), 0);
    cyc(1, mkword(8'h5A, 1), 1);
    chk("init_drop", {29'd0, data_valid, locked, err_count != 0}, 32'h0);
    frame(9'h0A5, 1, 0);
    frame(9'h0A5, 0, 1);

    // Reset asserted mid-frame aborts immediately.
    cyc(1, mkword(8'($urandom), 1), 0);
    #2 reset = 1'b0;
    IsReceive = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    @(negedge sys_clk);
    reset = 1'b1;
    frame(9'h0A5, 1, 0);
    chk("midrst_1sync", {31'd0, locked}, 32'h0);
    frame(9'h0A5, 1, 0);

    // Saturate err_count with an all-bad payload stream.
    while (m_err < 65535) frame(9'h0A5, 2, 0);
    frame(9'h0A5, 2, 0);
    chk("err_sat", {16'd0, err_count}, 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/receiver_framer.md
RECEIVER_FRAMER -- requirements
Module: receiver_framer

Interface
REQ-001 The block SHALL have one clock, sys_clk; reset SHALL be asynchronous and active-low, on port reset.
REQ-002 Ports SHALL be:
- sys_clk  in  1  system clock; all state on rising edge
- reset  in  1  async active-low reset
- init_tab  in  1  sync reinit pulse: clear err_count, force HUNT
- IsReceive  in  1  word enable; channel_in sampled only when 1
- channel_in  in  9  channel word: [7:0] data, [8] parity bit
- data_out  out  8  descrambled payload byte
- data_valid  out  1  one-cycle strobe, data_out valid
- parity_err  out  1  one-cycle strobe, coincident with data_valid, word parity bad
- locked  out  1  framer in LOCK
- err_count  out  16  saturating parity-error count

Function
REQ-003 Word format SHALL be: valid parity when XOR of all 9 bits of channel_in = 0.
REQ-004 Frame SHALL be 16 words: position 0 = sync word 9'h0A5, positions 1..15 = scrambled payload.
REQ-005 The 4-bit word counter SHALL advance once per accepted word (IsReceive=1) and wrap 15->0; it SHALL hold when IsReceive=0.
REQ-006 States SHALL be HUNT, VERIFY and LOCK; reset state SHALL be HUNT.
REQ-007 In HUNT, an accepted word equal to 9'h0A5 SHALL move the block to VERIFY and set the counter to 1; all other words SHALL be ignored.
REQ-008 In VERIFY, at counter=0, a word equal to 9'h0A5 SHALL move the block to LOCK; any other word SHALL move it to HUNT.
REQ-009 In LOCK, at counter=0, a non-sync word SHALL increment the 2-bit miss counter; a sync word SHALL clear it; a third consecutive miss SHALL move the block to HUNT and clear the miss counter.
REQ-010 locked SHALL be 1 exactly while the state is LOCK, asserting the cycle after the second sync word is sampled.
REQ-011 Descrambler: the 8-bit Fibonacci LFSR s SHALL be seeded to 8'hFF on every accepted counter=0 word; on each accepted payload word, data_out SHALL = channel_in[7:0] XOR s, then s SHALL become {s[6:0], s[7]^s[5]^s[4]^s[3]}.
REQ-012 Payload output SHALL occur only in LOCK: for each accepted payload word, data_valid SHALL pulse 1 cycle, registered, one cycle after the sample edge.
REQ-013 Sync words and words accepted in HUNT or VERIFY SHALL NOT produce data_valid.
REQ-014 On a LOCK payload word with bad parity, data SHALL still be output, parity_err SHALL = 1 with data_valid, and err_count SHALL increment.
REQ-015 err_count SHALL saturate at 16'hFFFF.
REQ-016 Sync words with bad parity SHALL count as misses, not as parity errors.
REQ-017 init_tab=1 SHALL take priority over a simultaneous accepted word: that word SHALL be discarded.
REQ-018 On init_tab=1 the block SHALL go to HUNT and clear err_count, the miss counter, the word counter, data_valid and parity_err; the LFSR SHALL be set to 8'hFF.
REQ-019 IsReceive=0 SHALL hold the LFSR, counters and state, with data_valid=0 and parity_err=0.
REQ-020 When the block drops from LOCK to HUNT, the following words SHALL NOT produce data_valid until LOCK is regained.

Reset
REQ-021 While reset=0, outputs SHALL be: data_out=8'h00, data_valid=0, parity_err=0, locked=0, err_count=0; state SHALL be HUNT, all counters 0, LFSR 8'hFF.
REQ-022 Reset asserted mid-frame SHALL abort immediately; after release, lock SHALL require two fresh sync words.

Verification
REQ-023 Two frames, sync 9'h0A5, first payload 9'h0FF -> locked=1 after the second sync; that frame's first payload gives data_out=8'h00 with data_valid=1.
REQ-024 In LOCK, payload 9'h1FF (bad parity) -> parity_err=1 with data_valid=1; err_count increments by 1.
REQ-025 In LOCK, three consecutive frames with position-0 word 9'h000 -> locked=0 after the third; no data_valid until two new syncs are received.
REQ-026 In LOCK, IsReceive=0 for 5 cycles mid-frame -> no strobes; LFSR and counter resume unchanged; descrambled bytes match the golden model.
REQ-027 init_tab=1 coincident with a valid payload word -> word dropped; locked=0 and err_count=0 next cycle.
REQ-028 err_count preloaded near 16'hFFFF (via bad-parity stream) -> holds at 16'hFFFF on further errors.
